// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the RV32I
//   5-stage pipeline. It holds the fetch PC (PCF) and talks to instruction
//   memory over a req/gnt/rvalid port. Only one request may be in flight.
//   If a response arrives while decode is stalled, a one-entry skid buffer
//   keeps it until decode can accept it. Cycles with no instruction to
//   deliver load a NOP bubble into IF/ID.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   StallF         freeze PCF and block new requests
//   StallD         hold the IF/ID register
//   FlushD         load a bubble into IF/ID
//   PCSrcE         taken branch/jump in EX: redirect to PCTargetE
//   PCTargetE      redirect target (bits [1:0] forced to 0)
//   imem_req       request valid (only in IDLE)
//   imem_addr      request address (always PCF)
//   imem_gnt       request accepted this cycle
//   imem_rvalid    response valid
//   imem_rdata     response instruction word
//   InstrD         instruction presented to decode
//   PCD, PCPlus4D  PC of InstrD and PC+4 (mod 2^32)
//   ValidD         1 = real fetched instruction, 0 = bubble
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // IDLE: may issue a request; WAIT: request granted, awaiting data;
    // HOLD: skid buffer full, waiting for decode; DROP: awaiting a response
    // that a redirect has already made obsolete.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetchState_t;

    fetchState_t stateReg, stateNext;
    logic [31:0] pcfReg, pcfNext;
    logic [31:0] pcfPlus4;
    logic [31:0] skidInstrReg;
    logic [31:0] skidPcReg;

    logic captureSkid;   // park the arriving response in the skid buffer
    logic deliverMem;    // arriving response goes straight into IF/ID
    logic deliverSkid;   // skid buffer contents go into IF/ID
    logic advancePc;     // the fetched word has been consumed: PCF += 4

    assign pcfPlus4  = pcfReg + 32'd4;
    assign imem_addr = pcfReg;

    always_comb begin
        stateNext   = stateReg;
        imem_req    = 1'b0;
        captureSkid = 1'b0;
        deliverMem  = 1'b0;
        deliverSkid = 1'b0;
        advancePc   = 1'b0;
        case (stateReg)
            IDLE: begin
                imem_req = ~StallF & ~PCSrcE;
                if (imem_req && imem_gnt) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (PCSrcE) begin
                        stateNext = IDLE;            // wrong-path word, discard
                    end else if (StallD) begin
                        captureSkid = 1'b1;
                        advancePc   = 1'b1;
                        stateNext   = HOLD;
                    end else begin
                        // A FlushD without a redirect overrides the load, so
                        // the word is consumed but never reaches decode.
                        deliverMem = ~FlushD;
                        advancePc  = 1'b1;
                        stateNext  = IDLE;
                    end
                end else if (PCSrcE) begin
                    stateNext = DROP;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    stateNext = IDLE;                // discard skid contents
                end else if (!StallD) begin
                    deliverSkid = 1'b1;
                    stateNext   = IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // A redirect beats StallF so a taken branch is never lost to a stall.
    always_comb begin
        pcfNext = pcfReg;
        if (PCSrcE) begin
            pcfNext = {PCTargetE[31:2], 2'b00};
        end else if (StallF) begin
            pcfNext = pcfReg;
        end else if (advancePc) begin
            pcfNext = pcfPlus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            pcfReg       <= RESET_PC;
            skidInstrReg <= NOP_INSTR;
            skidPcReg    <= 32'd0;
            InstrD       <= NOP_INSTR;
            PCD          <= 32'd0;
            PCPlus4D     <= 32'd4;
            ValidD       <= 1'b0;
        end else begin
            stateReg <= stateNext;
            pcfReg   <= pcfNext;
            // PCF cannot move while in WAIT without a redirect, so it is
            // still the address of the word being captured.
            if (captureSkid) begin
                skidInstrReg <= imem_rdata;
                skidPcReg    <= pcfReg;
            end
            if (FlushD) begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end else if (StallD) begin
                ValidD <= ValidD;
            end else if (deliverMem) begin
                InstrD   <= imem_rdata;
                PCD      <= pcfReg;
                PCPlus4D <= pcfPlus4;
                ValidD   <= 1'b1;
            end else if (deliverSkid) begin
                InstrD   <= skidInstrReg;
                PCD      <= skidPcReg;
                PCPlus4D <= skidPcReg + 32'd4;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;         // bubble; PCD/PCPlus4D held
                ValidD <= 1'b0;
            end
        end
    end

endmodule
